serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu.sv | 146 ++++++++++++++
 tb/tb_serial_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU (add / AND / NOT a / output disable).
// One operand bit is processed per cycle, LSB first, through a single
// one-bit datapath. The result is published only when the operation
// completes and is held until the next completion or reset.
//
// Handshake: start is a request sampled on the rising edge of clk. It is
// accepted only in IDLE or DONE. While RUN is active, busy is high and
// start is ignored. done is a one-cycle pulse that marks the cycle in
// which result and c_out first show the new values.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output tri   [WIDTH-1:0] result,
  output logic             c_out,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_OFF = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             hiz_q;

  logic             accept;
  logic             last_bit;
  logic             alu_bit;
  logic             alu_carry;
  logic [WIDTH-1:0] res_next;

  // Next state, request acceptance and the one-bit ALU.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_bit  = 1'b0;
    alu_bit   = 1'b0;
    alu_carry = 1'b0;

    unique case (op_q)
      OP_ADD: begin
        alu_bit   = a_sh[0] ^ b_sh[0] ^ carry_q;
        alu_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
      end
      OP_AND:  alu_bit = a_sh[0] & b_sh[0];
      OP_NOT:  alu_bit = ~a_sh[0];
      default: alu_bit = 1'b0;
    endcase
    res_next = {alu_bit, res_sh[WIDTH-1:1]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = (op == OP_OFF) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          last_bit = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and the serial shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      res_sh  <= '0;
      op_q    <= op;
      carry_q <= (op == OP_ADD) ? c_in : 1'b0;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next;
      carry_q <= (op_q == OP_ADD) ? alu_carry : 1'b0;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Published outputs: updated only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      c_out_q  <= 1'b0;
      hiz_q    <= 1'b0;
    end else if (accept && op == OP_OFF) begin
      c_out_q <= 1'b0;
      hiz_q   <= 1'b1;
    end else if (last_bit) begin
      result_q <= res_next;
      c_out_q  <= (op_q == OP_ADD) ? alu_carry : 1'b0;
      hiz_q    <= 1'b0;
    end
  end

  assign result    = hiz_q ? {WIDTH{1'bz}} : result_q;
  assign c_out     = c_out_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed testbench for serial_alu (WIDTH = 8). The result net is a tri1,
// so a released (high-Z) bus reads as all ones.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         busy, done, c_out;
  logic [1:0]   state_dbg;
  tri1  [W-1:0] result_w;

  int n_cmp = 0;
  int n_err = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .result    (result_w),
    .c_out     (c_out),
    .state_dbg (state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for done, check busy length, outputs and
  // that done is a single-cycle pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic ci, input logic [W-1:0] er,
                       input logic ec, input int eb);
    int nb = 0;
    int t  = 0;
    @(negedge clk);
    op = o; a = xa; b = xb; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 50) begin
      if (busy) nb++;
      t++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(eb));
    check({tag, "_result"}, 32'(result_w), 32'(er));
    check({tag, "_c_out"}, 32'(c_out), 32'(ec));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_hold"}, 32'(result_w), 32'(er));
  endtask

  // Wait for done counting busy cycles, starting from an already counted total.
  task automatic wait_done(input int nb_in, output int nb_out);
    int t = 0;
    nb_out = nb_in;
    while (!done && t < 50) begin
      if (busy) nb_out++;
      t++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb;
    int dn;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0; c_in = 1'b0;

    // reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_result", 32'(result_w), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add with carry ripple through every bit
    do_op("add_ff_01", 2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
    do_op("add_3c_5a_c1", 2'd0, 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 8);
    do_op("and_f0_3c", 2'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 8);
    do_op("not_a5", 2'd2, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0, 8);
    // output disable: bus released (reads as pulled-up ones), no busy
    do_op("off", 2'd3, 8'h12, 8'h34, 1'b1, 8'hFF, 1'b0, 0);
    do_op("and_after_off", 2'd1, 8'h0F, 8'hFF, 1'b0, 8'h0F, 1'b0, 8);

    // start during RUN is ignored
    @(negedge clk);
    op = 2'd0; a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_hold_in_run", 32'(result_w), 32'h0F);
    @(negedge clk);
    @(negedge clk);
    op = 2'd2; a = 8'h00; b = 8'h00; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, nb);
    check("ign_done", 32'(done), 32'd1);
    check("ign_busy_cycles", 32'(nb), 32'd8);
    check("ign_result", 32'(result_w), 32'h46);
    check("ign_c_out", 32'(c_out), 32'd0);

    // back-to-back: start accepted in DONE
    @(negedge clk);
    op = 2'd1; a = 8'hAA; b = 8'h0F; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, nb);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_result", 32'(result_w), 32'h0A);
    op = 2'd0; a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_busy", 32'(busy), 32'd1);
    check("b2b_no_idle_done", 32'(done), 32'd0);
    wait_done(0, nb);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_busy", 32'(nb), 32'd8);
    check("b2b_second_result", 32'(result_w), 32'h00);
    check("b2b_second_c_out", 32'(c_out), 32'd1);

    // reset during RUN aborts with no done pulse
    @(negedge clk);
    op = 2'd0; a = 8'h55; b = 8'h11; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result_w), 32'h00);
    check("mid_rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_rst_no_done", 32'(dn), 32'd0);
    do_op("add_after_rst", 2'd0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
